// File: rtl/load_align_unit.sv
// Load alignment unit: fetches the word(s) holding a byte/half/word load,
// extracts the addressed bytes and sign- or zero-extends them to 32 bits.
module load_align_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  output logic        ld_done,
  output logic [31:0] ld_data,
  output logic        ld_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ_LO = 2'd1;
  localparam logic [1:0] REQ_HI = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [1:0]  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] lo_q, lo_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        ld_done_q, ld_done_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_err_q, ld_err_d;

  function automatic logic isLegal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic crossesWord(input logic [2:0] f3, input logic [1:0] off);
    logic isHalf;
    isHalf = (f3 == F3_LH) || (f3 == F3_LHU);
    return (isHalf && (off == 2'd3)) || ((f3 == F3_LW) && (off != 2'd0));
  endfunction

  // Shift the little-endian {hi,lo} pair down to the addressed byte, then extend.
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] wide;
    logic [31:0] v;
    logic [31:0] res;
    wide = {hi, lo} >> {off, 3'b000};
    v    = wide[31:0];
    case (f3)
      F3_LB:   res = {{24{v[7]}}, v[7:0]};
      F3_LBU:  res = {24'b0, v[7:0]};
      F3_LH:   res = {{16{v[15]}}, v[15:0]};
      F3_LHU:  res = {16'b0, v[15:0]};
      F3_LW:   res = v;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    funct3_d   = funct3_q;
    lo_d       = lo_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ld_done_d  = 1'b0;
    ld_data_d  = ld_data_q;
    ld_err_d   = ld_err_q;

    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          off_d    = ld_addr[1:0];
          funct3_d = ld_funct3;
          if (isLegal(ld_funct3)) begin
            mem_req_d  = 1'b1;
            mem_addr_d = {ld_addr[31:2], 2'b00};
            state_d    = REQ_LO;
          end else begin
            // Illegal loads skip memory entirely and answer on the next cycle.
            ld_done_d = 1'b1;
            ld_err_d  = 1'b1;
            ld_data_d = 32'h0;
            state_d   = RESP;
          end
        end
      end
      REQ_LO: begin
        if (mem_rvalid) begin
          if (crossesWord(funct3_q, off_q)) begin
            lo_d       = mem_rdata;
            mem_addr_d = mem_addr_q + 32'd4;
            state_d    = REQ_HI;
          end else begin
            ld_data_d = extract(funct3_q, off_q, 32'h0, mem_rdata);
            ld_done_d = 1'b1;
            ld_err_d  = 1'b0;
            mem_req_d = 1'b0;
            state_d   = RESP;
          end
        end
      end
      REQ_HI: begin
        if (mem_rvalid) begin
          ld_data_d = extract(funct3_q, off_q, mem_rdata, lo_q);
          ld_done_d = 1'b1;
          ld_err_d  = 1'b0;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      off_q      <= 2'd0;
      funct3_q   <= 3'd0;
      lo_q       <= 32'h0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      ld_done_q  <= 1'b0;
      ld_data_q  <= 32'h0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      funct3_q   <= funct3_d;
      lo_q       <= lo_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ld_done_q  <= ld_done_d;
      ld_data_q  <= ld_data_d;
      ld_err_q   <= ld_err_d;
    end
  end

  assign ld_ready = (state_q == IDLE);
  assign ld_done  = ld_done_q;
  assign ld_data  = ld_data_q;
  assign ld_err   = ld_err_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule
